// File: rtl/bus_invert_encoder.sv
// Bus-invert encoder: sends In_Data or ~In_Data so at most NrOfBits/2 bus lines toggle per word.
// One registered output stage, 1-cycle latency; In_Ready drops only while a held word is stalled.
module bus_invert_encoder #(
  parameter int NrOfBits = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NrOfBits-1:0] In_Data,
  input  logic                In_Valid,
  output logic                In_Ready,
  output logic [NrOfBits-1:0] Out_Data,
  output logic                Out_Invert,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [15:0]         Inv_Count
);

  localparam int              HW   = $clog2(NrOfBits + 1);
  localparam logic [HW-1:0]   HALF = HW'(NrOfBits / 2);

  logic [NrOfBits-1:0] out_dat_q, out_dat_d;
  logic                out_inv_q, out_inv_d;
  logic                out_vld_q, out_vld_d;
  logic [15:0]         inv_count_q, inv_count_d;

  logic                in_rdy;
  logic                accept;
  logic                xfer;
  logic [NrOfBits-1:0] diff;
  logic [HW-1:0]       hd;
  logic                do_inv;

  assign in_rdy = !out_vld_q || Out_Ready;
  assign accept = In_Valid && in_rdy;
  assign xfer   = out_vld_q && Out_Ready;

  // Distance is measured against the last driven bus word, valid or not.
  always_comb begin
    diff = In_Data ^ out_dat_q;
    hd   = '0;
    for (int i = 0; i < NrOfBits; i++) begin
      hd = hd + {{(HW-1){1'b0}}, diff[i]};
    end
    do_inv = (hd > HALF);
  end

  always_comb begin
    out_dat_d   = out_dat_q;
    out_inv_d   = out_inv_q;
    out_vld_d   = out_vld_q;
    inv_count_d = inv_count_q;
    if (accept) begin
      out_dat_d = do_inv ? ~In_Data : In_Data;
      out_inv_d = do_inv;
      out_vld_d = 1'b1;
      if (do_inv && (inv_count_q != 16'hFFFF)) begin
        inv_count_d = inv_count_q + 16'd1;
      end
    end else if (xfer) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_dat_q   <= '0;
      out_inv_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      inv_count_q <= '0;
    end else begin
      out_dat_q   <= out_dat_d;
      out_inv_q   <= out_inv_d;
      out_vld_q   <= out_vld_d;
      inv_count_q <= inv_count_d;
    end
  end

  assign In_Ready   = in_rdy;
  assign Out_Data   = out_dat_q;
  assign Out_Invert = out_inv_q;
  assign Out_Valid  = out_vld_q;
  assign Inv_Count  = inv_count_q;

endmodule

// File: tb/tb_bus_invert_encoder.sv
// Directed and random checks of bus_invert_encoder (NrOfBits = 8) against a word-level reference model.
module tb_bus_invert_encoder;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [7:0]  In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  Out_Data;
  logic        Out_Invert;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Inv_Count;

  bus_invert_encoder #(.NrOfBits(8)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .In_Data    (In_Data),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Out_Data   (Out_Data),
    .Out_Invert (Out_Invert),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Inv_Count  (Inv_Count)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the word on the bus, its invert flag, occupancy, counter.
  logic [7:0]  m_bus = 8'h00;
  logic        m_inv = 1'b0;
  logic        m_vld = 1'b0;
  logic [15:0] m_cnt = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "/out_data"},  {24'h0, Out_Data},   {24'h0, m_bus});
    chk({tag, "/out_inv"},   {31'h0, Out_Invert}, {31'h0, m_inv});
    chk({tag, "/out_vld"},   {31'h0, Out_Valid},  {31'h0, m_vld});
    chk({tag, "/inv_count"}, {16'h0, Inv_Count},  {16'h0, m_cnt});
  endtask

  // Drive is already applied; check In_Ready, advance one edge, check outputs.
  task automatic cyc(input string tag);
    logic acc;
    int   h;
    #1;
    chk({tag, "/in_rdy"}, {31'h0, In_Ready}, {31'h0, (!m_vld || Out_Ready)});
    acc = In_Valid && (!m_vld || Out_Ready);
    if (acc) begin
      h = $countones(In_Data ^ m_bus);
      if (h > 4) begin
        m_bus = ~In_Data;
        m_inv = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_bus = In_Data;
        m_inv = 1'b0;
      end
      m_vld = 1'b1;
    end else if (m_vld && Out_Ready) begin
      m_vld = 1'b0;
    end
    @(posedge Clock);
    #1;
    n_vec++;
    chk_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    In_Valid  = v;
    In_Data   = d;
    Out_Ready = r;
  endtask

  initial begin
    Reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    // Reset forces outputs without a clock edge.
    #2 Reset_n = 1'b0;
    #1;
    n_vec++;
    chk("reset/out_vld",   {31'h0, Out_Valid},  32'h0);
    chk("reset/out_data",  {24'h0, Out_Data},   32'h0);
    chk("reset/out_inv",   {31'h0, Out_Invert}, 32'h0);
    chk("reset/inv_count", {16'h0, Inv_Count},  32'h0);
    chk("reset/in_rdy",    {31'h0, In_Ready},   32'h1);
    @(posedge Clock);
    @(posedge Clock);
    #1 Reset_n = 1'b1;

    // First accept after reset: 0x00 against reference 0x00.
    drive(1'b1, 8'h00, 1'b1);
    cyc("first");
    chk("first/data_const", {24'h0, Out_Data}, 32'h00);
    chk("first/vld_const",  {31'h0, Out_Valid}, 32'h1);

    // 0xFF against 0x00 (H=8) inverts; 0xFE against 0x00 (H=7) inverts.
    drive(1'b1, 8'hFF, 1'b1);
    cyc("h8");
    chk("h8/data_const", {24'h0, Out_Data},   32'h00);
    chk("h8/inv_const",  {31'h0, Out_Invert}, 32'h1);
    chk("h8/cnt_const",  {16'h0, Inv_Count},  32'h1);
    drive(1'b1, 8'hFE, 1'b1);
    cyc("h7");
    chk("h7/data_const", {24'h0, Out_Data},   32'h01);
    chk("h7/inv_const",  {31'h0, Out_Invert}, 32'h1);
    chk("h7/cnt_const",  {16'h0, Inv_Count},  32'h2);

    // Return bus to 0x00, then tie case 0x0F (H=4) is not inverted.
    drive(1'b1, 8'h00, 1'b1);
    cyc("to_zero");
    drive(1'b1, 8'h0F, 1'b1);
    cyc("tie");
    chk("tie/data_const", {24'h0, Out_Data},   32'h0F);
    chk("tie/inv_const",  {31'h0, Out_Invert}, 32'h0);
    chk("tie/cnt_const",  {16'h0, Inv_Count},  32'h2);

    // Backpressure: three stalled cycles, then Out_Ready releases the pending 0xA5.
    drive(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("stall");
      chk("stall/in_rdy_const", {31'h0, In_Ready}, 32'h0);
      chk("stall/data_hold",    {24'h0, Out_Data}, 32'h0F);
    end
    drive(1'b1, 8'hA5, 1'b1);
    cyc("release");
    chk("release/data_const", {24'h0, Out_Data}, 32'hA5);
    drive(1'b0, 8'h33, 1'b1);
    cyc("drain");
    chk("drain/vld_const", {31'h0, Out_Valid}, 32'h0);
    chk("drain/data_keep", {24'h0, Out_Data},  32'hA5);

    // Streaming 0x00, 0xFE, 0x01 back to back.
    drive(1'b1, 8'h00, 1'b1);
    cyc("stream0");
    chk("stream0/pair", {23'h0, Out_Data, Out_Invert}, {23'h0, 8'h00, 1'b0});
    drive(1'b1, 8'hFE, 1'b1);
    cyc("stream1");
    chk("stream1/pair", {23'h0, Out_Data, Out_Invert}, {23'h0, 8'h01, 1'b1});
    chk("stream1/vld",  {31'h0, Out_Valid}, 32'h1);
    drive(1'b1, 8'h01, 1'b1);
    cyc("stream2");
    chk("stream2/pair", {23'h0, Out_Data, Out_Invert}, {23'h0, 8'h01, 1'b0});
    chk("stream2/vld",  {31'h0, Out_Valid}, 32'h1);

    // Reset pulse between edges while FULL.
    drive(1'b0, 8'h00, 1'b0);
    Reset_n = 1'b0;
    #2;
    n_vec++;
    m_bus = 8'h00; m_inv = 1'b0; m_vld = 1'b0; m_cnt = 16'h0000;
    chk_outputs("midrst");
    chk("midrst/in_rdy", {31'h0, In_Ready}, 32'h1);
    Reset_n = 1'b1;
    #1;
    @(posedge Clock);
    #1;

    // Preload the counter at its ceiling, then an inverted word must not wrap it.
    force dut.inv_count_d = 16'hFFFF;
    @(posedge Clock);
    #1;
    release dut.inv_count_d;
    m_cnt = 16'hFFFF;
    n_vec++;
    chk("sat/preload", {16'h0, Inv_Count}, 32'hFFFF);
    drive(1'b1, 8'hFF, 1'b1);
    cyc("sat");
    chk("sat/cnt_const", {16'h0, Inv_Count},  32'hFFFF);
    chk("sat/inv_const", {31'h0, Out_Invert}, 32'h1);

    // Reset again so the random phase exercises the counter from zero.
    drive(1'b0, 8'h00, 1'b0);
    Reset_n = 1'b0;
    #2;
    m_bus = 8'h00; m_inv = 1'b0; m_vld = 1'b0; m_cnt = 16'h0000;
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
